mem_wb_stage: RTL and testbench

- MEM/WB pipeline stage that feeds the register file write port (RegWrite/waddr/wdata).
- Holds one retiring instruction and, for loads, waits for data-memory read data.
- Extracts and extends load bytes/halves, then drives exactly one regfile write per retired instruction.
- Provides backpressure to MEM and supports flush, including discard of an orphaned in-flight load response.

---
 rtl/mem_wb_stage.sv | 126 ++++++++++++
 tb/tb_mem_wb_stage.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: holds one retiring instruction, waits for load data,
// extends load bytes/halves and issues exactly one register-file write per instruction.
module mem_wb_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    output logic              mem_allowin,
    input  logic              mem_wreg,
    input  logic [ADDR_W-1:0] mem_waddr,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              mem_load,
    input  logic [2:0]        mem_ltype,
    input  logic [1:0]        mem_addr_lo,
    input  logic              dm_rvalid,
    input  logic [DATA_W-1:0] dm_rdata,
    input  logic              flush,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              wb_busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_dropPending;
    logic              r_wreg;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic [2:0]        r_ltype;
    logic [1:0]        r_addrLo;

    logic              w_xfer;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_loadData;

    assign mem_allowin = ((r_state == S_IDLE) || (r_state == S_WRITE)) && !flush;
    assign w_xfer      = mem_valid && mem_allowin;

    // A flush in the write cycle kills the write even though the state is WRITE.
    assign RegWrite = (r_state == S_WRITE) && r_wreg && !flush;
    assign waddr    = r_waddr;
    assign wdata    = r_wdata;
    assign wb_busy  = (r_state != S_IDLE);

    always_comb begin
        w_byte = dm_rdata[7:0];
        case (r_addrLo)
            2'd0:    w_byte = dm_rdata[7:0];
            2'd1:    w_byte = dm_rdata[15:8];
            2'd2:    w_byte = dm_rdata[23:16];
            default: w_byte = dm_rdata[31:24];
        endcase
        w_half = r_addrLo[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        case (r_ltype)
            3'b000:  w_loadData = {{(DATA_W-8){w_byte[7]}}, w_byte};
            3'b001:  w_loadData = {{(DATA_W-8){1'b0}}, w_byte};
            3'b010:  w_loadData = {{(DATA_W-16){w_half[15]}}, w_half};
            3'b011:  w_loadData = {{(DATA_W-16){1'b0}}, w_half};
            default: w_loadData = dm_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_dropPending <= 1'b0;
            r_wreg        <= 1'b0;
            r_waddr       <= '0;
            r_wdata       <= '0;
            r_ltype       <= 3'b000;
            r_addrLo      <= 2'b00;
        end else if (flush) begin
            r_state <= S_IDLE;
            // Killing an outstanding load orphans its response unless it arrives right now.
            if (r_state == S_WAIT) begin
                if (!dm_rvalid) begin
                    r_dropPending <= 1'b1;
                end
            end else if (dm_rvalid) begin
                r_dropPending <= 1'b0;
            end
        end else begin
            case (r_state)
                S_WAIT: begin
                    if (dm_rvalid) begin
                        if (r_dropPending) begin
                            r_dropPending <= 1'b0;
                        end else begin
                            r_wdata <= w_loadData;
                            r_state <= S_WRITE;
                        end
                    end
                end
                default: begin
                    if (dm_rvalid) begin
                        r_dropPending <= 1'b0;
                    end
                    if (w_xfer) begin
                        r_wreg  <= mem_wreg;
                        r_waddr <= mem_waddr;
                        if (mem_load) begin
                            r_ltype  <= mem_ltype;
                            r_addrLo <= mem_addr_lo;
                            r_state  <= S_WAIT;
                        end else begin
                            r_wdata <= mem_result;
                            r_state <= S_WRITE;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: expected register writes are queued when
// stimulus is driven and compared whenever the stage asserts RegWrite.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic        mem_allowin;
    logic        mem_wreg;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_result;
    logic        mem_load;
    logic [2:0]  mem_ltype;
    logic [1:0]  mem_addr_lo;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        flush;
    logic        RegWrite;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        wb_busy;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t expQ[$];
    wr_t monExp;
    int  vectors = 0;
    int  miscompares = 0;

    mem_wb_stage #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_allowin(mem_allowin),
        .mem_wreg(mem_wreg), .mem_waddr(mem_waddr), .mem_result(mem_result),
        .mem_load(mem_load), .mem_ltype(mem_ltype), .mem_addr_lo(mem_addr_lo),
        .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .flush(flush),
        .RegWrite(RegWrite), .waddr(waddr), .wdata(wdata), .wb_busy(wb_busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Every write the DUT retires must match the oldest queued expectation.
    always @(negedge clk) begin
        if (RegWrite === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedWrite", {31'b0, RegWrite}, 32'h0);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("sbWaddr", {27'b0, waddr}, {27'b0, monExp.a});
                checkOutput("sbWdata", wdata, monExp.d);
            end
        end
    end

    function automatic logic [31:0] loadModel(input logic [2:0] lt, input logic [1:0] lo, input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(d >> (8 * lo));
        h = 16'(d >> (lo[1] ? 16 : 0));
        case (lt)
            3'd0:    return {{24{b[7]}}, b};
            3'd1:    return {24'b0, b};
            3'd2:    return {{16{h[15]}}, h};
            3'd3:    return {16'b0, h};
            default: return d;
        endcase
    endfunction

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic wr, input logic [4:0] a,
                                 input logic [31:0] res, input logic ld,
                                 input logic [2:0] lt, input logic [1:0] lo);
        mem_valid   = v;
        mem_wreg    = wr;
        mem_waddr   = a;
        mem_result  = res;
        mem_load    = ld;
        mem_ltype   = lt;
        mem_addr_lo = lo;
    endtask

    task automatic doLoad(input logic [4:0] a, input logic [2:0] lt, input logic [1:0] lo,
                          input int gap, input logic [31:0] d, input logic [31:0] exp);
        applyStimulus(1, 1, a, 32'h0, 1, lt, lo);
        @(negedge clk);
        checkOutput("loadAllowin", {31'b0, mem_allowin}, 32'h1);
        nextCycle();
        applyStimulus(0, 0, 5'd0, 32'h0, 0, 3'd0, 2'd0);
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            checkOutput("waitAllowin", {31'b0, mem_allowin}, 32'h0);
            checkOutput("waitNoWrite", {31'b0, RegWrite}, 32'h0);
            nextCycle();
        end
        dm_rvalid = 1'b1;
        dm_rdata  = d;
        expQ.push_back(wr_t'({a, exp}));
        @(negedge clk);
        checkOutput("rvalidAllowin", {31'b0, mem_allowin}, 32'h0);
        checkOutput("waitBusy", {31'b0, wb_busy}, 32'h1);
        nextCycle();
        dm_rvalid = 1'b0;
        @(negedge clk);
        checkOutput("loadWrite", {31'b0, RegWrite}, 32'h1);
        nextCycle();
        @(negedge clk);
        checkOutput("loadWriteOnce", {31'b0, RegWrite}, 32'h0);
        nextCycle();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [2:0]  lt;
        logic [1:0]  lo;
        logic [31:0] d;
        rst = 1'b0;
        flush = 1'b0;
        dm_rvalid = 1'b0;
        dm_rdata = 32'h0;
        applyStimulus(0, 0, 5'd0, 32'h0, 0, 3'd0, 2'd0);
        #2;
        checkOutput("rstRegWrite", {31'b0, RegWrite}, 32'h0);
        checkOutput("rstWaddr", {27'b0, waddr}, 32'h0);
        checkOutput("rstWdata", wdata, 32'h0);
        checkOutput("rstBusy", {31'b0, wb_busy}, 32'h0);
        nextCycle();
        nextCycle();
        rst = 1'b1;
        nextCycle();

        // Single non-load
        applyStimulus(1, 1, 5'd5, 32'h1234_5678, 0, 3'd0, 2'd0);
        expQ.push_back(wr_t'({5'd5, 32'h1234_5678}));
        @(negedge clk);
        checkOutput("aluAllowin", {31'b0, mem_allowin}, 32'h1);
        nextCycle();
        applyStimulus(0, 0, 5'd0, 32'h0, 0, 3'd0, 2'd0);
        @(negedge clk);
        checkOutput("aluWrite", {31'b0, RegWrite}, 32'h1);
        nextCycle();
        @(negedge clk);
        checkOutput("aluWriteOnce", {31'b0, RegWrite}, 32'h0);
        checkOutput("aluIdle", {31'b0, wb_busy}, 32'h0);
        nextCycle();

        // Loads from the plan, including minimum latency (gap 0)
        doLoad(5'd2, 3'd0, 2'd3, 2, 32'h80FF_0000, 32'hFFFF_FF80);
        doLoad(5'd6, 3'd3, 2'd2, 1, 32'h8001_7FFF, 32'h0000_8001);
        doLoad(5'd7, 3'd2, 2'd0, 0, 32'h8001_7FFF, 32'h0000_7FFF);
        doLoad(5'd8, 3'd4, 2'd1, 1, 32'h8001_7FFF, 32'h8001_7FFF);
        doLoad(5'd0, 3'd1, 2'd1, 0, 32'h0000_9A00, 32'h0000_009A);

        // Back-to-back non-loads
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1, 1, 5'(i), 32'h111 * i, 0, 3'd0, 2'd0);
            expQ.push_back(wr_t'({5'(i), 32'h111 * i}));
            @(negedge clk);
            checkOutput("b2bAllowin", {31'b0, mem_allowin}, 32'h1);
            if (i > 1) checkOutput("b2bWrite", {31'b0, RegWrite}, 32'h1);
            nextCycle();
        end
        applyStimulus(0, 0, 5'd0, 32'h0, 0, 3'd0, 2'd0);
        @(negedge clk);
        checkOutput("b2bWriteLast", {31'b0, RegWrite}, 32'h1);
        nextCycle();
        @(negedge clk);
        checkOutput("b2bDone", {31'b0, RegWrite}, 32'h0);
        nextCycle();

        // Flush in WAIT orphans the response; next LW must drop it
        applyStimulus(1, 1, 5'd7, 32'h0, 1, 3'd4, 2'd0);
        nextCycle();
        applyStimulus(0, 0, 5'd0, 32'h0, 0, 3'd0, 2'd0);
        flush = 1'b1;
        @(negedge clk);
        checkOutput("flushAllowin", {31'b0, mem_allowin}, 32'h0);
        nextCycle();
        flush = 1'b0;
        applyStimulus(1, 1, 5'd4, 32'h0, 1, 3'd4, 2'd0);
        @(negedge clk);
        checkOutput("postFlushIdle", {31'b0, wb_busy}, 32'h0);
        checkOutput("postFlushAllowin", {31'b0, mem_allowin}, 32'h1);
        nextCycle();
        applyStimulus(0, 0, 5'd0, 32'h0, 0, 3'd0, 2'd0);
        nextCycle();
        dm_rvalid = 1'b1;
        dm_rdata = 32'hDEAD_BEEF;
        nextCycle();
        dm_rvalid = 1'b0;
        @(negedge clk);
        checkOutput("dropNoWrite", {31'b0, RegWrite}, 32'h0);
        checkOutput("dropStillWait", {31'b0, wb_busy}, 32'h1);
        nextCycle();
        dm_rvalid = 1'b1;
        dm_rdata = 32'h0000_0042;
        expQ.push_back(wr_t'({5'd4, 32'h0000_0042}));
        nextCycle();
        dm_rvalid = 1'b0;
        @(negedge clk);
        checkOutput("flushLoadWrite", {31'b0, RegWrite}, 32'h1);
        nextCycle();

        // Flush during WRITE suppresses the write
        applyStimulus(1, 1, 5'd9, 32'hCAFE_0009, 0, 3'd0, 2'd0);
        nextCycle();
        applyStimulus(0, 0, 5'd0, 32'h0, 0, 3'd0, 2'd0);
        flush = 1'b1;
        @(negedge clk);
        checkOutput("flushKillsWrite", {31'b0, RegWrite}, 32'h0);
        nextCycle();
        flush = 1'b0;
        @(negedge clk);
        checkOutput("flushWriteIdle", {31'b0, wb_busy}, 32'h0);
        nextCycle();

        // Flush coinciding with rvalid consumes it: no drop pending afterwards
        applyStimulus(1, 1, 5'd6, 32'h0, 1, 3'd4, 2'd0);
        nextCycle();
        applyStimulus(0, 0, 5'd0, 32'h0, 0, 3'd0, 2'd0);
        flush = 1'b1;
        dm_rvalid = 1'b1;
        dm_rdata = 32'h5555_5555;
        nextCycle();
        flush = 1'b0;
        dm_rvalid = 1'b0;
        doLoad(5'd6, 3'd4, 2'd0, 0, 32'h0BAD_F00D, 32'h0BAD_F00D);

        // Random loads against the extraction model
        for (int i = 0; i < 10; i++) begin
            lt = 3'($urandom_range(0, 7));
            lo = 2'($urandom_range(0, 3));
            d  = $urandom;
            doLoad(5'($urandom_range(1, 31)), lt, lo, $urandom_range(0, 2), d, loadModel(lt, lo, d));
        end

        // Asynchronous reset mid-WAIT
        applyStimulus(1, 1, 5'd3, 32'h0, 1, 3'd4, 2'd0);
        nextCycle();
        applyStimulus(0, 0, 5'd0, 32'h0, 0, 3'd0, 2'd0);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("asyncRegWrite", {31'b0, RegWrite}, 32'h0);
        checkOutput("asyncWaddr", {27'b0, waddr}, 32'h0);
        checkOutput("asyncWdata", wdata, 32'h0);
        checkOutput("asyncBusy", {31'b0, wb_busy}, 32'h0);
        nextCycle();
        rst = 1'b1;
        dm_rvalid = 1'b1;
        dm_rdata = 32'h7777_7777;
        nextCycle();
        dm_rvalid = 1'b0;
        @(negedge clk);
        checkOutput("postRstNoWrite", {31'b0, RegWrite}, 32'h0);
        checkOutput("postRstIdle", {31'b0, wb_busy}, 32'h0);
        nextCycle();
        nextCycle();

        checkOutput("sbEmpty", expQ.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
